// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner for the MAX3421E: synchronizes and debounces the raw pin,
// captures edges, counts rises and exposes it all through a small Avalon-MM slave.
module usb_gpx_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gpx_pin,
  output logic        gpx_level,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] count;
  logic [1:0]       edge_cap;
  logic [1:0]       edge_cap_next;
  logic [1:0]       irq_mask;
  logic [15:0]      rise_count;
  logic             accept;
  logic             rise;
  logic             fall;
  logic             unused_writedata;

  assign unused_writedata = ^writedata[31:2];

  // A new level is accepted on the edge where it has been seen for the full window.
  assign accept = (sync2 != stable) && (count == LAST_COUNT);
  assign rise   = accept & sync2;
  assign fall   = accept & ~sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      count  <= '0;
    end else begin
      sync1 <= gpx_pin;
      sync2 <= sync1;
      if (sync2 == stable) begin
        count <= '0;
      end else if (count == LAST_COUNT) begin
        stable <= sync2;
        count  <= '0;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Edge events are applied after the W1C clear so a coincident event wins.
  always_comb begin
    edge_cap_next = edge_cap;
    if (write && address == 2'd3) begin
      edge_cap_next = edge_cap_next & ~writedata[1:0];
    end
    edge_cap_next = edge_cap_next | {fall, rise};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap   <= 2'b00;
      irq_mask   <= 2'b00;
      rise_count <= 16'h0000;
    end else begin
      edge_cap <= edge_cap_next;
      if (write && address == 2'd2) begin
        irq_mask <= writedata[1:0];
      end
      if (write && address == 2'd1) begin
        rise_count <= rise ? 16'h0001 : 16'h0000;
      end else if (rise && rise_count != 16'hFFFF) begin
        rise_count <= rise_count + 16'h0001;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= 32'h0;
    end else begin
      case (address)
        2'd0:    readdata <= {31'b0, stable};
        2'd1:    readdata <= {16'b0, rise_count};
        2'd2:    readdata <= {30'b0, irq_mask};
        default: readdata <= {30'b0, edge_cap};
      endcase
    end
  end

  assign gpx_level = stable;
  assign irq       = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed self-checking bench for usb_gpx_conditioner at DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_usb_gpx_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic        gpx_pin;
  logic        gpx_level;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  usb_gpx_conditioner dut (
    .clk       (clk),
    .reset     (reset),
    .gpx_pin   (gpx_pin),
    .gpx_level (gpx_level),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write     = 1'b1;
    step(1);
    write     = 1'b0;
    writedata = 32'h0;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    step(1);
    data = readdata;
  endtask

  // Drives the pin to a new level and lets it fully settle through the debouncer.
  task automatic settlePin(input logic level);
    gpx_pin = level;
    step(6);
  endtask

  logic [31:0] rd;

  initial begin
    reset     = 1'b1;
    gpx_pin   = 1'b0;
    address   = 2'd0;
    write     = 1'b0;
    writedata = 32'h0;
    step(2);
    checkOutput("reset_level", {31'b0, gpx_level}, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("reset_readdata", readdata, 32'h0);
    reset = 1'b0;
    step(2);

    // Clean rise: accepted on the sixth edge after the pin changes.
    gpx_pin = 1'b1;
    step(5);
    checkOutput("rise_edge5_level", {31'b0, gpx_level}, 32'h0);
    step(1);
    checkOutput("rise_edge6_level", {31'b0, gpx_level}, 32'h1);
    checkOutput("rise_edge6_rd0", readdata, 32'h0);
    step(1);
    checkOutput("rise_rd0_latency", readdata, 32'h1);
    checkOutput("rise_irq_masked", {31'b0, irq}, 32'h0);
    readReg(2'd3, rd);
    checkOutput("rise_edge_cap", rd, 32'h1);
    readReg(2'd1, rd);
    checkOutput("rise_count_1", rd, 32'h1);

    applyStimulus(2'd3, 32'h1);
    settlePin(1'b0);
    checkOutput("fall_level", {31'b0, gpx_level}, 32'h0);
    readReg(2'd3, rd);
    checkOutput("fall_edge_cap", rd, 32'h2);
    applyStimulus(2'd3, 32'h3);
    readReg(2'd3, rd);
    checkOutput("w1c_clear", rd, 32'h0);

    // A three-cycle excursion must be rejected.
    gpx_pin = 1'b1;
    step(3);
    gpx_pin = 1'b0;
    step(8);
    checkOutput("glitch_level", {31'b0, gpx_level}, 32'h0);
    readReg(2'd3, rd);
    checkOutput("glitch_edge_cap", rd, 32'h0);
    readReg(2'd1, rd);
    checkOutput("glitch_rise_count", rd, 32'h1);

    // A four-cycle excursion is exactly long enough to be accepted.
    gpx_pin = 1'b1;
    step(4);
    gpx_pin = 1'b0;
    step(2);
    checkOutput("min_pulse_level", {31'b0, gpx_level}, 32'h1);
    step(10);
    checkOutput("min_pulse_back", {31'b0, gpx_level}, 32'h0);
    readReg(2'd3, rd);
    checkOutput("min_pulse_edge_cap", rd, 32'h3);
    applyStimulus(2'd3, 32'h3);

    // Interrupt on rise only.
    applyStimulus(2'd2, 32'h1);
    readReg(2'd2, rd);
    checkOutput("irq_mask_rd", rd, 32'h1);
    settlePin(1'b1);
    checkOutput("irq_on_rise", {31'b0, irq}, 32'h1);
    applyStimulus(2'd3, 32'h1);
    checkOutput("irq_cleared", {31'b0, irq}, 32'h0);
    settlePin(1'b0);
    checkOutput("irq_fall_masked", {31'b0, irq}, 32'h0);
    applyStimulus(2'd3, 32'h3);

    // Rise and W1C clear of bit0 on the same edge.
    gpx_pin = 1'b1;
    step(5);
    applyStimulus(2'd3, 32'h1);
    checkOutput("set_wins_level", {31'b0, gpx_level}, 32'h1);
    checkOutput("set_wins_irq", {31'b0, irq}, 32'h1);
    readReg(2'd3, rd);
    checkOutput("set_wins_edge_cap", rd, 32'h1);
    readReg(2'd1, rd);
    checkOutput("rise_count_4", rd, 32'h4);

    // Rise-count clear coincident with a rise.
    settlePin(1'b0);
    gpx_pin = 1'b1;
    step(5);
    applyStimulus(2'd1, 32'h0);
    readReg(2'd1, rd);
    checkOutput("clear_with_rise", rd, 32'h1);

    // Saturation: preload near the top instead of toggling 64K times.
    settlePin(1'b0);
    force dut.rise_count = 16'hFFFE;
    step(1);
    release dut.rise_count;
    settlePin(1'b1);
    readReg(2'd1, rd);
    checkOutput("count_reach_max", rd, 32'hFFFF);
    settlePin(1'b0);
    settlePin(1'b1);
    readReg(2'd1, rd);
    checkOutput("count_saturated", rd, 32'hFFFF);
    applyStimulus(2'd1, 32'h0);
    readReg(2'd1, rd);
    checkOutput("count_cleared", rd, 32'h0);

    // Address 0 writes and upper data bits are ignored.
    applyStimulus(2'd0, 32'hFFFF_FFFF);
    readReg(2'd2, rd);
    checkOutput("addr0_write_ignored", rd, 32'h1);
    applyStimulus(2'd2, 32'hFFFF_FFFE);
    readReg(2'd2, rd);
    checkOutput("mask_upper_ignored", rd, 32'h2);

    // Reset mid-count with pin high.
    settlePin(1'b0);
    checkOutput("pre_reset_irq", {31'b0, irq}, 32'h1);
    address = 2'd2;
    gpx_pin = 1'b1;
    step(4);
    checkOutput("pre_reset_rd", readdata, 32'h2);
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_level", {31'b0, gpx_level}, 32'h0);
    checkOutput("mid_reset_irq", {31'b0, irq}, 32'h0);
    checkOutput("mid_reset_rd", readdata, 32'h0);
    step(2);
    reset = 1'b0;
    step(5);
    checkOutput("post_reset_edge5", {31'b0, gpx_level}, 32'h0);
    step(1);
    checkOutput("post_reset_edge6", {31'b0, gpx_level}, 32'h1);
    checkOutput("post_reset_irq", {31'b0, irq}, 32'h0);
    readReg(2'd3, rd);
    checkOutput("post_reset_edge_cap", rd, 32'h1);
    readReg(2'd2, rd);
    checkOutput("post_reset_mask", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
